// File: rtl/spw_tx_credit_fifo.sv
// spw_tx_credit_fifo: FWFT N-Char queue gated by SpaceWire FCT credit (host in, data_tx/txwrite_tx/ready_tx_data out, credit 0..56)
module spw_tx_credit_fifo #(
  parameter int DEPTH = 64,
  parameter int AW = 6
) (
  input  logic          pclk_tx,
  input  logic          rst_tx,
  input  logic [8:0]    host_data_i,
  input  logic          host_wr_i,
  output logic          host_full_o,
  output logic [AW:0]   fifo_count_o,
  output logic          overflow_o,
  input  logic          link_run_i,
  input  logic          gotfct_tx,
  output logic [5:0]    credit_o,
  output logic          credit_error_o,
  output logic [8:0]    data_tx,
  output logic          txwrite_tx,
  input  logic          ready_tx_data
);
  logic [8:0] mem [DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] count;
  logic [5:0] credit;
  logic wr_ok, xfer, fct_ovf;
  logic [6:0] credit_sum;
  assign host_full_o = count == (AW+1)'(DEPTH);
  assign fifo_count_o = count;
  assign credit_o = credit;
  assign wr_ok = host_wr_i & ~host_full_o;
  assign txwrite_tx = link_run_i & (count != '0) & (credit != '0);
  assign xfer = txwrite_tx & ready_tx_data;
  assign fct_ovf = gotfct_tx & ({1'b0, credit} + 7'd8 > 7'd56);
  assign credit_sum = {1'b0, credit} + ((gotfct_tx & ~fct_ovf) ? 7'd8 : 7'd0) - {6'd0, xfer};
  assign data_tx = (count != '0) ? mem[rp] : 9'h000;
  always_ff @(posedge pclk_tx)
    if (wr_ok) mem[wp] <= host_data_i;
  always_ff @(posedge pclk_tx) begin
    if (rst_tx) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
      credit <= '0;
      overflow_o <= 1'b0;
      credit_error_o <= 1'b0;
    end else begin
      rp <= rp + AW'(xfer);
      wp <= wp + AW'(wr_ok);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(xfer);
      credit <= link_run_i ? credit_sum[5:0] : 6'd0;
      overflow_o <= host_wr_i & host_full_o;
      credit_error_o <= link_run_i & fct_ovf;
    end
  end
endmodule

// File: tb/tb_spw_tx_credit_fifo.sv
// tb_spw_tx_credit_fifo: directed self-checking bench for spw_tx_credit_fifo
module tb_spw_tx_credit_fifo;
  logic pclk_tx = 0, rst_tx = 0;
  logic [8:0] host_data_i = '0;
  logic host_wr_i = 0, link_run_i = 0, gotfct_tx = 0, ready_tx_data = 0;
  logic host_full_o, overflow_o, credit_error_o, txwrite_tx;
  logic [6:0] fifo_count_o;
  logic [5:0] credit_o;
  logic [8:0] data_tx;
  int checks = 0, errors = 0;
  spw_tx_credit_fifo dut (
    .pclk_tx(pclk_tx), .rst_tx(rst_tx), .host_data_i(host_data_i), .host_wr_i(host_wr_i),
    .host_full_o(host_full_o), .fifo_count_o(fifo_count_o), .overflow_o(overflow_o),
    .link_run_i(link_run_i), .gotfct_tx(gotfct_tx), .credit_o(credit_o),
    .credit_error_o(credit_error_o), .data_tx(data_tx), .txwrite_tx(txwrite_tx),
    .ready_tx_data(ready_tx_data)
  );
  always #5 pclk_tx = ~pclk_tx;
  task automatic tick();
    @(posedge pclk_tx);
    #1;
  endtask
  task automatic test_reset();
    rst_tx = 1;
    link_run_i = 1;
    tick();
    rst_tx = 0;
    link_run_i = 0;
    checks++; if (host_full_o !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", host_full_o); end
    checks++; if (fifo_count_o !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count_o); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    checks++; if (credit_o !== 6'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit_o); end
    checks++; if (credit_error_o !== 1'b0) begin errors++; $display("FAIL reset_cerr: got %b want 0", credit_error_o); end
    checks++; if (txwrite_tx !== 1'b0) begin errors++; $display("FAIL reset_txwrite: got %b want 0", txwrite_tx); end
    checks++; if (data_tx !== 9'h000) begin errors++; $display("FAIL reset_data: got %h want 000", data_tx); end
  endtask
  task automatic test_write_no_credit();
    logic [8:0] v [3] = '{9'h041, 9'h042, 9'h100};
    link_run_i = 1;
    for (int i = 0; i < 3; i++) begin
      host_data_i = v[i];
      host_wr_i = 1;
      tick();
    end
    host_wr_i = 0;
    checks++; if (fifo_count_o !== 7'd3) begin errors++; $display("FAIL nocred_count: got %0d want 3", fifo_count_o); end
    checks++; if (txwrite_tx !== 1'b0) begin errors++; $display("FAIL nocred_txwrite: got %b want 0", txwrite_tx); end
    checks++; if (credit_o !== 6'd0) begin errors++; $display("FAIL nocred_credit: got %0d want 0", credit_o); end
    checks++; if (data_tx !== 9'h041) begin errors++; $display("FAIL nocred_head: got %h want 041", data_tx); end
  endtask
  task automatic test_fct_drain();
    logic [8:0] v [3] = '{9'h041, 9'h042, 9'h100};
    gotfct_tx = 1;
    ready_tx_data = 1;
    tick();
    gotfct_tx = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (credit_o !== 6'(8 - i)) begin errors++; $display("FAIL drain_credit%0d: got %0d want %0d", i, credit_o, 8 - i); end
      checks++; if (txwrite_tx !== 1'b1 || data_tx !== v[i]) begin errors++; $display("FAIL drain_data%0d: got %b/%h want 1/%h", i, txwrite_tx, data_tx, v[i]); end
      tick();
    end
    ready_tx_data = 0;
    checks++; if (credit_o !== 6'd5) begin errors++; $display("FAIL drain_credit_end: got %0d want 5", credit_o); end
    checks++; if (txwrite_tx !== 1'b0 || fifo_count_o !== 7'd0) begin errors++; $display("FAIL drain_empty: got %b/%0d want 0/0", txwrite_tx, fifo_count_o); end
  endtask
  task automatic test_credit_max();
    link_run_i = 0;
    tick();
    link_run_i = 1;
    checks++; if (credit_o !== 6'd0) begin errors++; $display("FAIL max_linkoff: got %0d want 0", credit_o); end
    gotfct_tx = 1;
    for (int i = 0; i < 7; i++) tick();
    gotfct_tx = 0;
    checks++; if (credit_o !== 6'd56 || credit_error_o !== 1'b0) begin errors++; $display("FAIL max_56: got %0d/%b want 56/0", credit_o, credit_error_o); end
    gotfct_tx = 1;
    tick();
    gotfct_tx = 0;
    checks++; if (credit_error_o !== 1'b1 || credit_o !== 6'd56) begin errors++; $display("FAIL max_err: got %b/%0d want 1/56", credit_error_o, credit_o); end
    tick();
    checks++; if (credit_error_o !== 1'b0) begin errors++; $display("FAIL max_err_pulse: got %b want 0", credit_error_o); end
    host_data_i = 9'h055;
    host_wr_i = 1;
    tick();
    host_wr_i = 0;
    gotfct_tx = 1;
    ready_tx_data = 1;
    tick();
    gotfct_tx = 0;
    ready_tx_data = 0;
    checks++; if (credit_error_o !== 1'b1 || credit_o !== 6'd55 || fifo_count_o !== 7'd0) begin errors++; $display("FAIL max_err_xfer: got %b/%0d/%0d want 1/55/0", credit_error_o, credit_o, fifo_count_o); end
  endtask
  task automatic test_overflow_wrap();
    for (int i = 0; i < 64; i++) begin
      host_data_i = 9'(i * 7 + 3);
      host_wr_i = 1;
      tick();
    end
    checks++; if (host_full_o !== 1'b1 || fifo_count_o !== 7'd64) begin errors++; $display("FAIL ovf_full: got %b/%0d want 1/64", host_full_o, fifo_count_o); end
    host_data_i = 9'h1FF;
    tick();
    host_wr_i = 0;
    checks++; if (overflow_o !== 1'b1 || fifo_count_o !== 7'd64) begin errors++; $display("FAIL ovf_pulse: got %b/%0d want 1/64", overflow_o, fifo_count_o); end
    tick();
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b want 0", overflow_o); end
    link_run_i = 0;
    tick();
    link_run_i = 1;
    gotfct_tx = 1;
    for (int i = 0; i < 7; i++) tick();
    gotfct_tx = 0;
    ready_tx_data = 1;
    for (int i = 0; i < 56; i++) begin
      checks++; if (txwrite_tx !== 1'b1 || data_tx !== 9'(i * 7 + 3)) begin errors++; $display("FAIL wrap_data%0d: got %b/%h want 1/%h", i, txwrite_tx, data_tx, 9'(i * 7 + 3)); end
      tick();
    end
    checks++; if (credit_o !== 6'd0 || txwrite_tx !== 1'b0 || fifo_count_o !== 7'd8) begin errors++; $display("FAIL wrap_mid: got %0d/%b/%0d want 0/0/8", credit_o, txwrite_tx, fifo_count_o); end
    gotfct_tx = 1;
    tick();
    gotfct_tx = 0;
    for (int i = 56; i < 64; i++) begin
      checks++; if (txwrite_tx !== 1'b1 || data_tx !== 9'(i * 7 + 3)) begin errors++; $display("FAIL wrap_data%0d: got %b/%h want 1/%h", i, txwrite_tx, data_tx, 9'(i * 7 + 3)); end
      tick();
    end
    ready_tx_data = 0;
    checks++; if (credit_o !== 6'd0 || fifo_count_o !== 7'd0) begin errors++; $display("FAIL wrap_end: got %0d/%0d want 0/0", credit_o, fifo_count_o); end
  endtask
  task automatic test_stall();
    for (int i = 0; i < 9; i++) begin
      host_data_i = 9'h1A0 + 9'(i);
      host_wr_i = 1;
      tick();
    end
    host_wr_i = 0;
    gotfct_tx = 1;
    tick();
    gotfct_tx = 0;
    ready_tx_data = 1;
    for (int i = 0; i < 7; i++) tick();
    ready_tx_data = 0;
    checks++; if (credit_o !== 6'd1 || fifo_count_o !== 7'd2) begin errors++; $display("FAIL stall_setup: got %0d/%0d want 1/2", credit_o, fifo_count_o); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (txwrite_tx !== 1'b1 || data_tx !== 9'h1A7) begin errors++; $display("FAIL stall_hold%0d: got %b/%h want 1/1a7", i, txwrite_tx, data_tx); end
      tick();
    end
    ready_tx_data = 1;
    tick();
    ready_tx_data = 0;
    checks++; if (credit_o !== 6'd0 || txwrite_tx !== 1'b0 || fifo_count_o !== 7'd1) begin errors++; $display("FAIL stall_accept: got %0d/%b/%0d want 0/0/1", credit_o, txwrite_tx, fifo_count_o); end
  endtask
  task automatic test_link_drop_reset();
    gotfct_tx = 1;
    for (int i = 0; i < 3; i++) begin
      host_data_i = 9'h0F0 + 9'(i);
      host_wr_i = 1;
      tick();
    end
    gotfct_tx = 0;
    host_wr_i = 0;
    checks++; if (credit_o !== 6'd24 || fifo_count_o !== 7'd4) begin errors++; $display("FAIL drop_setup: got %0d/%0d want 24/4", credit_o, fifo_count_o); end
    ready_tx_data = 1;
    tick();
    checks++; if (credit_o !== 6'd23 || data_tx !== 9'h0F0) begin errors++; $display("FAIL drop_stream: got %0d/%h want 23/0f0", credit_o, data_tx); end
    link_run_i = 0;
    #1;
    checks++; if (txwrite_tx !== 1'b0) begin errors++; $display("FAIL drop_txwrite_now: got %b want 0", txwrite_tx); end
    tick();
    checks++; if (credit_o !== 6'd0 || fifo_count_o !== 7'd3 || data_tx !== 9'h0F0) begin errors++; $display("FAIL drop_kept: got %0d/%0d/%h want 0/3/0f0", credit_o, fifo_count_o, data_tx); end
    link_run_i = 1;
    gotfct_tx = 1;
    tick();
    gotfct_tx = 0;
    checks++; if (txwrite_tx !== 1'b1 || credit_o !== 6'd8) begin errors++; $display("FAIL rerun: got %b/%0d want 1/8", txwrite_tx, credit_o); end
    rst_tx = 1;
    host_wr_i = 1;
    tick();
    rst_tx = 0;
    host_wr_i = 0;
    ready_tx_data = 0;
    checks++; if (fifo_count_o !== 7'd0 || credit_o !== 6'd0 || txwrite_tx !== 1'b0 || data_tx !== 9'h000 || host_full_o !== 1'b0 || overflow_o !== 1'b0 || credit_error_o !== 1'b0)
      begin errors++; $display("FAIL midreset: got count=%0d credit=%0d txw=%b data=%h full=%b ovf=%b cerr=%b want all zero", fifo_count_o, credit_o, txwrite_tx, data_tx, host_full_o, overflow_o, credit_error_o); end
  endtask
  initial begin
    test_reset();
    test_write_no_credit();
    test_fct_drain();
    test_credit_max();
    test_overflow_wrap();
    test_stall();
    test_link_drop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spw_tx_credit_fifo.md
# spw_tx_credit_fifo

Transmit-side N-Char buffer and flow-control credit keeper, sitting directly upstream of the SpaceWire transmitter. Host N-Chars (8-bit data plus control flag: EOP/EEP) are queued in a first-word-fall-through FIFO. Each character is released to the transmitter via the `data_tx`/`txwrite_tx`/`ready_tx_data` handshake only while the link is running and outstanding FCT credit is non-zero. Received FCTs (`gotfct_tx`) add credit per ECSS-E-ST-50-12C: 8 N-Chars per FCT, 56 maximum.

## Interface
- `DEPTH`, 64: FIFO depth in N-Chars; power of two, ≥4.
- `AW`, 6: log2(`DEPTH`); count width is `AW+1`.

- `pclk_tx`  in  1: clock; all logic rising-edge.
- `rst_tx`  in  1: reset, synchronous, active-high.
- `host_data_i`  in  9: [8] control flag, [7:0] data/EOP(00)/EEP(01).
- `host_wr_i`  in  1: write strobe; one N-Char per cycle.
- `host_full_o`  out  1: FIFO full (count == `DEPTH`).
- `fifo_count_o`  out  `AW+1`: occupancy.
- `overflow_o`  out  1: one-cycle pulse on a write while full.
- `link_run_i`  in  1: link FSM in Run state.
- `gotfct_tx`  in  1: one-cycle pulse per received FCT.
- `credit_o`  out  6: outstanding credit, 0..56.
- `credit_error_o`  out  1: one-cycle pulse on credit overflow.
- `data_tx`  out  9: head-of-FIFO N-Char, to transmitter `data_tx_i`.
- `txwrite_tx`  out  1: N-Char valid, to transmitter.
- `ready_tx_data`  in  1: transmitter accepts `data_tx` this cycle.

## Operation
- Storage: `DEPTH`×9 RAM; read pointer `rp` and write pointer `wp` of width `AW` with natural wrap; separate `count` register of width `AW+1`.
- Write: `wr_ok = host_wr_i & (count != DEPTH)`. A write while full is dropped, asserts `overflow_o` for 1 cycle, and leaves the pointers unchanged.
  - A full FIFO rejects a write even if a read occurs in the same cycle.
- Offer: `txwrite_tx = link_run_i & (count != 0) & (credit != 0)`.
- Transfer: `xfer = txwrite_tx & ready_tx_data`. On transfer, `rp` increments and `count` decrements.
- `data_tx` is always `mem[rp]` (FWFT).
  - `data_tx` is stable while `txwrite_tx=1 & ready_tx_data=0`.
  - When the FIFO is empty, `data_tx` is don't-care but is driven 9'h000 after reset.
- Simultaneous write and transfer: both happen and `count` is unchanged. At `count==0` only the write happens, because `txwrite_tx` is low.
- Credit update, in priority order each cycle:
  - If `link_run_i=0`: credit ← 0; `gotfct_tx` is ignored, with no error.
  - Otherwise, `next = credit + 8*gotfct_tx - xfer`.
  - If `gotfct_tx` and `credit + 8 > 56`: `credit_error_o` pulses, the FCT is discarded, and credit ← `credit - xfer`.
  - Otherwise credit ← `next`.
  - Arithmetic is done at 7 bits; the stored value never exceeds 56 and never goes below 0.
- `link_run_i` falling does not flush the FIFO; queued data waits for the next Run with fresh credit.
- `rst_tx` clears pointers, `count`, credit, and pulse outputs, and empties the FIFO. RAM contents are not reset.

## Timing
- Reset values:
  - `host_full_o=0`, `fifo_count_o=0`, `overflow_o=0`.
  - `credit_o=0`, `credit_error_o=0`.
  - `txwrite_tx=0`, `data_tx=9'h000`.
- Write-to-offer latency: a write in cycle N is visible on `data_tx`/`fifo_count_o` in N+1. `txwrite_tx` can rise in N+1 if credit and link allow.
- FCT-to-offer latency: `gotfct_tx` in cycle N makes `credit_o` update in N+1, and `txwrite_tx` can rise in N+1.
- `txwrite_tx` is combinational from registered `count`/`credit` and the `link_run_i` input; no combinational path from `ready_tx_data` to `txwrite_tx`.
- Throughput: one N-Char per cycle while credit and data are available.
- `overflow_o` and `credit_error_o` are registered, asserted the cycle after the offending event.

## Test plan
- Reset, then `link_run_i=1` with no FCT; write 3 chars (9'h041, 9'h042, 9'h100) → `fifo_count_o=3`, `txwrite_tx=0`, `credit_o=0`.
- Same state, pulse `gotfct_tx` once and hold `ready_tx_data=1` → `credit_o=8`; 3 chars out in order 041, 042, 100; `credit_o=5`; `txwrite_tx` falls when empty.
- Pulse 7 FCTs → `credit_o=56`; an 8th FCT → `credit_error_o` 1 cycle, `credit_o` stays 56; 8th FCT together with a transfer → error, `credit_o=55`.
- Write 64 chars with `ready_tx_data=0` → `host_full_o=1`; a 65th write → `overflow_o` pulse, count 64; drain all 64 with credit 64 via multiple FCTs → data matches in order, pointers wrap cleanly.
- Credit 1, data queued: `ready_tx_data` low for 5 cycles → `data_tx` stable; single accept → `credit_o=0`, `txwrite_tx=0`, count down by 1.
- Credit 24, drop `link_run_i` mid-stream → `credit_o=0` next cycle, `txwrite_tx=0` at once, FIFO contents kept; `rst_tx` mid-stream → all outputs at reset values next cycle.
